// File: rtl/fm_mul_iter.sv
// fm_mul_iter: radix-2 shift-add significand multiplier with leading-one detection
module fm_mul_iter #(
    parameter int N_SIG = 11
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 start,
    input  logic [N_SIG-1:0]     a_sig,
    input  logic [N_SIG-1:0]     b_sig,
    input  logic [7:0]           ex_in,
    input  logic                 sign_in,
    output logic                 busy,
    output logic                 valid,
    output logic [2*N_SIG-1:0]   mul_out,
    output logic [4:0]           count,
    output logic                 zero,
    output logic [7:0]           ex_added,
    output logic                 out_sign
);
    localparam int W  = 2 * N_SIG;
    localparam int IW = $clog2(N_SIG + 1);

    typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d, mcand_q, mcand_d, mul_out_q, mul_out_d;
    logic [N_SIG-1:0] mplier_q, mplier_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [7:0]      ex_q, ex_d, ex_added_q, ex_added_d;
    logic            sign_q, sign_d, out_sign_q, out_sign_d;
    logic [4:0]      count_q, count_d, lead;
    logic            zero_q, zero_d, valid_q, valid_d;

    always_comb begin
        lead = '0;
        for (int i = 0; i < W; i++)
            if (acc_q[i]) lead = 5'(i);
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        iter_d     = iter_q;
        ex_d       = ex_q;
        sign_d     = sign_q;
        mul_out_d  = mul_out_q;
        count_d    = count_q;
        zero_d     = zero_q;
        ex_added_d = ex_added_q;
        out_sign_d = out_sign_q;
        valid_d    = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                mcand_d  = {{N_SIG{1'b0}}, a_sig};
                mplier_d = b_sig;
                acc_d    = '0;
                iter_d   = '0;
                ex_d     = ex_in;
                sign_d   = sign_in;
                state_d  = MUL;
            end
            MUL: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                iter_d   = iter_q + 1'b1;
                state_d  = (iter_q == IW'(N_SIG - 1)) ? NORM : MUL;
            end
            NORM: begin
                mul_out_d  = acc_q;
                count_d    = lead;
                zero_d     = (acc_q == '0);
                ex_added_d = ex_q;
                out_sign_d = sign_q;
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            iter_q     <= '0;
            ex_q       <= '0;
            sign_q     <= 1'b0;
            mul_out_q  <= '0;
            count_q    <= '0;
            zero_q     <= 1'b0;
            ex_added_q <= '0;
            out_sign_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            iter_q     <= iter_d;
            ex_q       <= ex_d;
            sign_q     <= sign_d;
            mul_out_q  <= mul_out_d;
            count_q    <= count_d;
            zero_q     <= zero_d;
            ex_added_q <= ex_added_d;
            out_sign_q <= out_sign_d;
            valid_q    <= valid_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign valid    = valid_q;
    assign mul_out  = mul_out_q;
    assign count    = count_q;
    assign zero     = zero_q;
    assign ex_added = ex_added_q;
    assign out_sign = out_sign_q;
endmodule
